// File: rtl/comma_aligner.sv
// comma_aligner: recovers 10-bit symbol boundaries from a serial stream using
// K28.5 commas in either running disparity (bit 9 is received first).
// Alignment is hunted in SEARCH, proven in CONFIRM and held in LOCKED.
// Optional build macro: ALIGN_LOSS_DETECT_EN -- when defined, a comma seen off
// the locked symbol grid drops lock and re-anchors on it; when undefined,
// lock is sticky until rst.
module comma_aligner (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       serialIn,
  output logic [9:0] dataOut,
  output logic       valid,
  output logic       commaDet,
  output logic       locked
);

  localparam int unsigned SYM_W = 10;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned WIN_W = 4;

  localparam logic [SYM_W-1:0] COMMA_NEG = 10'b0011111010;
  localparam logic [SYM_W-1:0] COMMA_POS = 10'b1100000101;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(SYM_W - 1);
  localparam logic [WIN_W-1:0] WIN_MAX   = {WIN_W{1'b1}};

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state;
  logic [SYM_W-1:0] sr;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIN_W-1:0] window;

  logic is_comma;
  logic aligned;
  logic capture;

  // Comma match on the fully shifted-in symbol and symbol-grid position
  assign is_comma = (sr == COMMA_NEG) || (sr == COMMA_POS);
  assign aligned  = (bit_cnt == LAST_BIT);

  // Decide whether this enabled edge latches sr into dataOut
  always_comb begin
    capture = 1'b0;
    case (state)
      SEARCH:  capture = is_comma;
      CONFIRM: capture = aligned || is_comma;
`ifdef ALIGN_LOSS_DETECT_EN
      LOCKED:  capture = aligned || is_comma;
`else
      LOCKED:  capture = aligned;
`endif
      default: capture = 1'b0;
    endcase
  end

  // Shift register, bit counter, alignment state machine and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= '0;
      bit_cnt  <= '0;
      window   <= '0;
      state    <= SEARCH;
      dataOut  <= '0;
      valid    <= 1'b0;
      commaDet <= 1'b0;
      locked   <= 1'b0;
    end else begin
      valid    <= 1'b0;
      commaDet <= 1'b0;
      if (enb) begin
        sr <= {sr[SYM_W-2:0], serialIn};

        // Counter wraps on its own in SEARCH; every capture restarts the symbol
        if (capture || aligned) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt <= CNT_W'(bit_cnt + 4'd1);
        end

        if (capture) begin
          dataOut  <= sr;
          valid    <= 1'b1;
          commaDet <= is_comma;
        end

        case (state)
          SEARCH: begin
            if (is_comma) begin
              state  <= CONFIRM;
              window <= '0;
            end
          end

          CONFIRM: begin
            if (aligned) begin
              if (is_comma) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end else if (window == WIN_MAX) begin
                state  <= SEARCH;
                window <= '0;
              end else begin
                window <= WIN_W'(window + 4'd1);
              end
            end else if (is_comma) begin
              // A comma off the current grid becomes the new anchor
              window <= '0;
            end
          end

          LOCKED: begin
`ifdef ALIGN_LOSS_DETECT_EN
            if (!aligned && is_comma) begin
              state  <= CONFIRM;
              window <= '0;
              locked <= 1'b0;
            end
`endif
          end

          default: begin
            state  <= SEARCH;
            window <= '0;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_comma_aligner.sv
// Directed bench for comma_aligner with a bit-history reference model.
module tb_comma_aligner;

  localparam logic [9:0] K_NEG = 10'b0011111010;
  localparam logic [9:0] K_POS = 10'b1100000101;
  localparam logic [9:0] D2AA  = 10'h2AA;
  localparam logic [9:0] D155  = 10'h155;
`ifdef ALIGN_LOSS_DETECT_EN
  localparam bit LD = 1'b1;
`else
  localparam bit LD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b0;
  logic       serialIn = 1'b0;
  logic [9:0] dataOut;
  logic       valid;
  logic       commaDet;
  logic       locked;

  comma_aligner dut (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .serialIn (serialIn),
    .dataOut  (dataOut),
    .valid    (valid),
    .commaDet (commaDet),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int vcount = 0;
  int last_vcyc = 0;
  int gap = 0;
  int v0 = 0;

  // Reference model: last received bits, alignment phase, bits since capture
  bit         hist[$];
  int         m_phase = 0;   // 0 hunting, 1 proving, 2 locked
  int         m_since = 0;
  int         m_win = 0;
  logic [9:0] e_data = '0;
  logic       e_valid = 1'b0;
  logic       e_cd = 1'b0;
  logic       e_locked = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] window10();
    logic [9:0] v;
    v = '0;
    for (int i = 0; i < 10; i++)
      if (i < hist.size()) v[i] = hist[hist.size() - 1 - i];
    return v;
  endfunction

  task automatic model(input logic b, input logic e, input logic r);
    logic [9:0] cur;
    bit cm, al, cap;
    if (r) begin
      hist.delete();
      m_phase = 0; m_since = 0; m_win = 0;
      e_data = '0; e_valid = 1'b0; e_cd = 1'b0; e_locked = 1'b0;
      return;
    end
    e_valid = 1'b0;
    e_cd = 1'b0;
    if (!e) return;
    cur = window10();
    cm  = (cur == K_NEG) || (cur == K_POS);
    al  = (m_phase != 0) && (m_since == 9);
    cap = 1'b0;
    case (m_phase)
      0: if (cm) begin cap = 1'b1; m_phase = 1; m_win = 0; end
      1: begin
        if (al) begin
          cap = 1'b1;
          if (cm) m_phase = 2;
          else if (m_win == 15) begin m_phase = 0; m_win = 0; end
          else m_win++;
        end else if (cm) begin
          cap = 1'b1; m_win = 0;
        end
      end
      default: begin
        if (al) cap = 1'b1;
        else if (cm && LD) begin cap = 1'b1; m_phase = 1; m_win = 0; end
      end
    endcase
    m_since = cap ? 0 : m_since + 1;
    if (cap) begin e_valid = 1'b1; e_data = cur; e_cd = cm; end
    e_locked = (m_phase == 2);
    hist.push_back(b);
    if (hist.size() > 10) void'(hist.pop_front());
  endtask

  // One clock: drive, advance model, compare every output
  task automatic step(input logic b, input logic e, input logic r);
    serialIn = b; enb = e; rst = r;
    @(posedge clk);
    model(b, e, r);
    #1;
    cyc++;
    chk("valid", 32'(valid), 32'(e_valid));
    chk("commaDet", 32'(commaDet), 32'(e_cd));
    chk("locked", 32'(locked), 32'(e_locked));
    chk("dataOut", 32'(dataOut), 32'(e_data));
    if (valid === 1'b1) begin
      vcount++;
      gap = cyc - last_vcyc;
      last_vcyc = cyc;
    end
  endtask

  task automatic send_sym(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) step(s[i], 1'b1, 1'b0);
  endtask

  task automatic head(input logic [9:0] s);
    step(s[9], 1'b1, 1'b0);
  endtask

  task automatic tail(input logic [9:0] s);
    for (int i = 8; i >= 0; i--) step(s[i], 1'b1, 1'b0);
  endtask

  initial begin
    // Reset (enb high too: rst wins)
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(dataOut), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);

    // Acquire: 3 stray bits, comma, 0x2AA, comma
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    send_sym(K_NEG);
    head(D2AA);
    chk("acq_comma_valid", 32'(valid), 32'd1);
    chk("acq_comma_data", 32'(dataOut), 32'h0FA);
    chk("acq_comma_det", 32'(commaDet), 32'd1);
    chk("acq_locked0", 32'(locked), 32'd0);
    tail(D2AA);
    head(K_NEG);
    chk("acq_2aa_valid", 32'(valid), 32'd1);
    chk("acq_2aa_data", 32'(dataOut), 32'h2AA);
    chk("acq_2aa_gap", 32'(gap), 32'd10);
    tail(K_NEG);
    head(D155);
    chk("acq_locked1", 32'(locked), 32'd1);
    chk("acq_comma2_det", 32'(commaDet), 32'd1);

    // Locked data stream: five 0x155 symbols
    v0 = vcount;
    tail(D155);
    for (int k = 0; k < 5; k++) begin
      head(D155);
      chk("lock_valid", 32'(valid), 32'd1);
      chk("lock_data", 32'(dataOut), 32'h155);
      chk("lock_gap", 32'(gap), 32'd10);
      tail(D155);
    end
    chk("lock_pulses", 32'(vcount - v0), 32'd5);

    // Slip: 3 extra bits then comma, while locked
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    send_sym(K_NEG);
    head(D155);
    chk("slip_locked", 32'(locked), LD ? 32'd0 : 32'd1);
    chk("slip_valid", 32'(valid), LD ? 32'd1 : 32'd0);
    tail(D155);
    send_sym(K_NEG);
    head(D155);
    chk("slip_relock", 32'(locked), 32'd1);
    tail(D155);

    // CONFIRM timeout after 16 non-comma symbols
    step(1'b0, 1'b1, 1'b1);
    v0 = vcount;
    send_sym(K_NEG);
    head(D155);
    tail(D155);
    for (int k = 0; k < 15; k++) begin
      head(D155);
      tail(D155);
    end
    head(D155);
    chk("tmo_pulses", 32'(vcount - v0), 32'd17);
    chk("tmo_locked", 32'(locked), 32'd0);
    tail(D155);
    v0 = vcount;
    send_sym(D155);
    send_sym(D155);
    chk("tmo_quiet", 32'(vcount - v0), 32'd0);
    send_sym(K_POS);
    head(D155);
    chk("tmo_rehunt", 32'(valid), 32'd1);
    chk("tmo_rehunt_data", 32'(dataOut), 32'(K_POS));
    tail(D155);

    // Enable gap of 7 cycles inside a symbol
    step(1'b0, 1'b1, 1'b1);
    send_sym(K_NEG);
    send_sym(K_NEG);
    head(D155);
    chk("enb_locked", 32'(locked), 32'd1);
    for (int i = 8; i >= 5; i--) step(D155[i], 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 4; i >= 0; i--) step(D155[i], 1'b1, 1'b0);
    head(D155);
    chk("enb_valid", 32'(valid), 32'd1);
    chk("enb_data", 32'(dataOut), 32'h155);
    chk("enb_gap", 32'(gap), 32'd17);

    // Reset while locked, mid-symbol, then relock on two commas
    for (int i = 8; i >= 5; i--) step(D155[i], 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("mrst_valid", 32'(valid), 32'd0);
    chk("mrst_det", 32'(commaDet), 32'd0);
    chk("mrst_data", 32'(dataOut), 32'd0);
    chk("mrst_locked", 32'(locked), 32'd0);
    send_sym(K_NEG);
    head(K_NEG);
    chk("mrst_c1_valid", 32'(valid), 32'd1);
    chk("mrst_c1_locked", 32'(locked), 32'd0);
    tail(K_NEG);
    head(D155);
    chk("mrst_c2_locked", 32'(locked), 32'd1);
    tail(D155);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
